reg_bank_mp: RTL and testbench

//  Parametrised multi-port register bank: NREGS x WIDTH storage, one write port, two read ports, per-register busy scoreboard.

---
 rtl/reg_bank_mp_pkg.sv | 18 +
 rtl/reg_bank_mp_if.sv | 37 +++
 rtl/reg_bank_mp_scoreboard.sv | 49 ++++
 rtl/reg_bank_mp.sv | 108 ++++++++++
 tb/tb_reg_bank_mp.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_mp_pkg.sv
// Package regbank_pkg: shared defaults and helpers for the register bank and
// the decode/writeback logic that talks to it.
//   REGBANK_WIDTH_DEF  default data width
//   REGBANK_NREGS_DEF  default register count
//   regbank_clog2()    address-width helper usable in parameter expressions
package regbank_pkg;

    localparam int REGBANK_WIDTH_DEF = 32;
    localparam int REGBANK_NREGS_DEF = 16;

    function automatic int regbank_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/reg_bank_mp_if.sv
// Interface reg_bank_mp_if: bundles the write, reserve and two read ports of
// the register bank.
//   master modport: decode/writeback side (drives strobes, addresses, data)
//   slave  modport: the register bank (returns registered data and busy bits)
// Handshake: there is no valid/ready flow control. wr_en and rsv_en are
// single-cycle strobes that take effect on the clock edge where they are high.
// Reads are always accepted, and their result appears one cycle later.
interface reg_bank_mp_if
    import regbank_pkg::*;
#(
    parameter int WIDTH = REGBANK_WIDTH_DEF,
    parameter int NREGS = REGBANK_NREGS_DEF
);
    localparam int AW = regbank_clog2(NREGS);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic             busy_a;
    logic             busy_b;

    modport master (
        output wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, busy_a, busy_b
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, busy_a, busy_b
    );
endinterface

// File: rtl/reg_bank_mp_scoreboard.sv
// Module regbank_scoreboard: one busy flag per register, plus two registered
// lookups.
//   clk, rst             clock and synchronous active-high reset
//   rel_en_i/rel_addr_i  release (clear busy) of a register, driven by a write
//   rsv_en_i/rsv_addr_i  reserve (set busy) of a register
//   rd_addr_a_i/_b_i     lookup addresses
//   busy_a_o/busy_b_o    pre-edge busy bit of the looked-up address, one cycle later
// When a reserve and a release target the same register, the reserve wins,
// because a new producer has been issued.
module regbank_scoreboard #(
    parameter int NREGS = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rel_en_i,
    input  logic [AW-1:0] rel_addr_i,
    input  logic          rsv_en_i,
    input  logic [AW-1:0] rsv_addr_i,
    input  logic [AW-1:0] rd_addr_a_i,
    input  logic [AW-1:0] rd_addr_b_i,
    output logic          busy_a_o,
    output logic          busy_b_o
);
    logic [NREGS-1:0] busy_q, busy_d;
    logic             busy_a_q, busy_b_q;

    always_comb begin
        busy_d = busy_q;
        if (rel_en_i) busy_d[rel_addr_i] = 1'b0;
        if (rsv_en_i) busy_d[rsv_addr_i] = 1'b1;  // applied last, so it has priority
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            busy_a_q <= 1'b0;
            busy_b_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            // The lookup reads the state before this edge, so nothing is bypassed here.
            busy_a_q <= busy_q[rd_addr_a_i];
            busy_b_q <= busy_q[rd_addr_b_i];
        end
    end

    assign busy_a_o = busy_a_q;
    assign busy_b_o = busy_b_q;
endmodule

// File: rtl/reg_bank_mp.sv
// Module reg_bank_mp: NREGS x WIDTH register bank with one write port, two
// synchronous read ports and a per-register busy scoreboard.
//   clk  clock; all state changes on the rising edge
//   rst  synchronous active-high reset; it overrides every strobe
//   bus  reg_bank_mp_if.slave: write, reserve, read addresses, and the
//        registered read data and busy bits
// ZERO_REG=1 makes register 0 read as zero. Writes and reservations to
// register 0 are then dropped at the input, so it never holds data or busy.
// Optional macro REGBANK_BYPASS_EN selects the read-during-write behaviour:
//   defined   write-first. A read of the address being written returns
//             wr_data and busy 0, or busy 1 when that address is reserved
//             in the same cycle.
//   undefined read-first. The read returns the old value and the old busy bit.
module reg_bank_mp
    import regbank_pkg::*;
#(
    parameter int WIDTH    = REGBANK_WIDTH_DEF,
    parameter int NREGS    = REGBANK_NREGS_DEF,
    parameter int ZERO_REG = 1
) (
    input logic           clk,
    input logic           rst,
    reg_bank_mp_if.slave  bus
);
    localparam int AW = regbank_clog2(NREGS);

    logic [WIDTH-1:0] mem_q [NREGS];
    logic [WIDTH-1:0] rd_data_a_q, rd_data_b_q;
    logic [WIDTH-1:0] rd_data_a_d, rd_data_b_d;
    logic             wr_eff, rsv_eff;
    logic             sb_busy_a, sb_busy_b;

    // Strobes to register 0 are squashed here, so storage and scoreboard both ignore them.
    assign wr_eff  = bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_addr  == '0));
    assign rsv_eff = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));

    regbank_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .rel_en_i    (wr_eff),
        .rel_addr_i  (bus.wr_addr),
        .rsv_en_i    (rsv_eff),
        .rsv_addr_i  (bus.rsv_addr),
        .rd_addr_a_i (bus.rd_addr_a),
        .rd_addr_b_i (bus.rd_addr_b),
        .busy_a_o    (sb_busy_a),
        .busy_b_o    (sb_busy_b)
    );

`ifdef REGBANK_BYPASS_EN
    logic hit_a, hit_b, rsv_hit_a, rsv_hit_b;
    logic byp_a_q, byp_b_q, byp_busy_a_q, byp_busy_b_q;

    assign hit_a     = wr_eff  && (bus.wr_addr  == bus.rd_addr_a);
    assign hit_b     = wr_eff  && (bus.wr_addr  == bus.rd_addr_b);
    assign rsv_hit_a = rsv_eff && (bus.rsv_addr == bus.rd_addr_a);
    assign rsv_hit_b = rsv_eff && (bus.rsv_addr == bus.rd_addr_b);

    always_comb begin
        rd_data_a_d = hit_a ? bus.wr_data : mem_q[bus.rd_addr_a];
        rd_data_b_d = hit_b ? bus.wr_data : mem_q[bus.rd_addr_b];
    end

    // A write hit overrides the scoreboard's pre-edge busy bit for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_a_q      <= 1'b0;
            byp_b_q      <= 1'b0;
            byp_busy_a_q <= 1'b0;
            byp_busy_b_q <= 1'b0;
        end else begin
            byp_a_q      <= hit_a;
            byp_b_q      <= hit_b;
            byp_busy_a_q <= rsv_hit_a;
            byp_busy_b_q <= rsv_hit_b;
        end
    end

    assign bus.busy_a = byp_a_q ? byp_busy_a_q : sb_busy_a;
    assign bus.busy_b = byp_b_q ? byp_busy_b_q : sb_busy_b;
`else
    always_comb begin
        rd_data_a_d = mem_q[bus.rd_addr_a];
        rd_data_b_d = mem_q[bus.rd_addr_b];
    end

    assign bus.busy_a = sb_busy_a;
    assign bus.busy_b = sb_busy_b;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else begin
            if (wr_eff) mem_q[bus.wr_addr] <= bus.wr_data;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
        end
    end

    assign bus.rd_data_a = rd_data_a_q;
    assign bus.rd_data_b = rd_data_b_q;
endmodule

// File: tb/tb_reg_bank_mp.sv
// Bench for reg_bank_mp. Two instances share one stimulus stream:
// dut_z1 has ZERO_REG=1 and dut_z0 has ZERO_REG=0. A reference model predicts
// each read result when the inputs are driven, pushes it to a queue, and the
// entry is popped and checked once the registered outputs are available.
module tb_reg_bank_mp;
    import regbank_pkg::*;

    localparam int W  = 32;
    localparam int N  = 16;
    localparam int AW = 4;
    localparam int EW = 2 * W + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          wr_en = 1'b0, rsv_en = 1'b0;
    logic [AW-1:0] wr_addr = '0, rsv_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
    logic [W-1:0]  wr_data = '0;

    reg_bank_mp_if #(.WIDTH(W), .NREGS(N)) if_z1 ();
    reg_bank_mp_if #(.WIDTH(W), .NREGS(N)) if_z0 ();

    assign if_z1.wr_en = wr_en;         assign if_z0.wr_en = wr_en;
    assign if_z1.wr_addr = wr_addr;     assign if_z0.wr_addr = wr_addr;
    assign if_z1.wr_data = wr_data;     assign if_z0.wr_data = wr_data;
    assign if_z1.rsv_en = rsv_en;       assign if_z0.rsv_en = rsv_en;
    assign if_z1.rsv_addr = rsv_addr;   assign if_z0.rsv_addr = rsv_addr;
    assign if_z1.rd_addr_a = rd_addr_a; assign if_z0.rd_addr_a = rd_addr_a;
    assign if_z1.rd_addr_b = rd_addr_b; assign if_z0.rd_addr_b = rd_addr_b;

    reg_bank_mp #(.WIDTH(W), .NREGS(N), .ZERO_REG(1)) dut_z1 (.clk(clk), .rst(rst), .bus(if_z1));
    reg_bank_mp #(.WIDTH(W), .NREGS(N), .ZERO_REG(0)) dut_z0 (.clk(clk), .rst(rst), .bus(if_z0));

    // Reference model, indexed [zero_reg][register].
    logic [W-1:0] m_mem  [2][N];
    logic         m_busy [2][N];

    logic [EW-1:0] exp_q1[$];
    logic [EW-1:0] exp_q0[$];
    int tests = 0;
    int fails = 0;

    function automatic logic [W:0] model_port(input int z, input logic [AW-1:0] a);
        logic [W-1:0] d;
        logic         b;
        logic         wr_ok, rsv_ok;
        wr_ok  = wr_en  && !(z == 1 && wr_addr  == '0);
        rsv_ok = rsv_en && !(z == 1 && rsv_addr == '0);
        d = m_mem[z][a];
        b = m_busy[z][a];
`ifdef REGBANK_BYPASS_EN
        if (wr_ok && wr_addr == a) begin
            d = wr_data;
            b = rsv_ok && (rsv_addr == a);
        end
`else
        if (rsv_ok) b = b;  // read-first: no forwarding of data or busy
`endif
        if (rst || (z == 1 && a == '0)) begin
            d = '0;
            b = 1'b0;
        end
        return {d, b};
    endfunction

    task automatic model_update(input int z);
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_mem[z][i]  = '0;
                m_busy[z][i] = 1'b0;
            end
        end else begin
            if (wr_en && !(z == 1 && wr_addr == '0)) begin
                m_mem[z][wr_addr]  = wr_data;
                m_busy[z][wr_addr] = 1'b0;
            end
            if (rsv_en && !(z == 1 && rsv_addr == '0)) m_busy[z][rsv_addr] = 1'b1;
        end
    endtask

    // One clock: predict, advance the model, clock the DUTs, then check away from the edge.
    task automatic step(input string tag);
        logic [EW-1:0] e, o;
        exp_q1.push_back({model_port(1, rd_addr_a), model_port(1, rd_addr_b)});
        exp_q0.push_back({model_port(0, rd_addr_a), model_port(0, rd_addr_b)});
        model_update(1);
        model_update(0);
        @(posedge clk);
        #1;
        e = exp_q1.pop_front();
        o = {if_z1.rd_data_a, if_z1.busy_a, if_z1.rd_data_b, if_z1.busy_b};
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s z1: got a=%h/%b b=%h/%b want a=%h/%b b=%h/%b", tag,
                   o[EW-1 -: W], o[W+1], o[W:1], o[0], e[EW-1 -: W], e[W+1], e[W:1], e[0]);
        end
        e = exp_q0.pop_front();
        o = {if_z0.rd_data_a, if_z0.busy_a, if_z0.rd_data_b, if_z0.busy_b};
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s z0: got a=%h/%b b=%h/%b want a=%h/%b b=%h/%b", tag,
                   o[EW-1 -: W], o[W+1], o[W:1], o[0], e[EW-1 -: W], e[W+1], e[W:1], e[0]);
        end
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    initial begin
        for (int z = 0; z < 2; z++)
            for (int i = 0; i < N; i++) begin
                m_mem[z][i]  = 'x;
                m_busy[z][i] = 1'bx;
            end

        // Reset, then sweep every address on both ports.
        rst = 1'b1;
        step("reset");
        step("reset_hold");
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            rd_addr_a = AW'(i);
            rd_addr_b = AW'(N - 1 - i);
            step("reset_sweep");
        end

        // Write r5, then read it on both ports.
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEAD_BEEF;
        step("wr_r5");
        idle(); rd_addr_a = 4'd5; rd_addr_b = 4'd5;
        step("rd_r5_both");
        step("rd_r5_result");

        // Write to r0: suppressed only with ZERO_REG=1.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h0000_1234;
        step("wr_r0");
        idle(); rd_addr_a = 4'd0; rd_addr_b = 4'd0;
        step("rd_r0");
        step("rd_r0_result");

        // Read-during-write on r3.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h11;
        step("wr_r3_first");
        wr_data = 32'h22; rd_addr_a = 4'd3; rd_addr_b = 4'd5;
        step("rdw_r3");
        idle();
        step("rd_r3_after");

        // Reserve, then write plus reserve together, then write alone, on r7.
        rsv_en = 1'b1; rsv_addr = 4'd7; rd_addr_a = 4'd7; rd_addr_b = 4'd7;
        step("rsv_r7");
        idle();
        step("rd_r7_busy");
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h55; rsv_en = 1'b1; rsv_addr = 4'd7;
        step("wr_rsv_r7");
        idle();
        step("rd_r7_still_busy");
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h56;
        step("wr_r7_release");
        idle();
        step("rd_r7_free");

        // Reserve r0: ignored only with ZERO_REG=1.
        rsv_en = 1'b1; rsv_addr = 4'd0; rd_addr_a = 4'd0;
        step("rsv_r0");
        idle();
        step("rd_r0_busy");

        // Random mix of all strobes.
        for (int k = 0; k < 200; k++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = AW'($urandom_range(0, N - 1));
            wr_data   = $urandom;
            rsv_en    = 1'($urandom_range(0, 1));
            rsv_addr  = AW'($urandom_range(0, N - 1));
            rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, N - 1));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? rsv_addr : AW'($urandom_range(0, N - 1));
            step("random");
        end

        // Load r1..r15 and reserve r2, then reset with a write pending.
        idle();
        for (int i = 1; i < N; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = 32'hA500_0000 + 32'(i);
            rd_addr_a = AW'(i - 1);
            step("load");
        end
        wr_en = 1'b0; rsv_en = 1'b1; rsv_addr = 4'd2;
        step("rsv_r2");
        rsv_en = 1'b0; rd_addr_a = 4'd2; rd_addr_b = 4'd9;
        step("rd_r2_pre_reset");
        rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'hFFFF_FFFF;
        step("reset_with_wr");
        rst = 1'b0; idle();
        for (int i = 0; i < N; i++) begin
            rd_addr_a = AW'(i);
            rd_addr_b = AW'(i ^ 1);
            step("post_reset_sweep");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
